// File: rtl/data_mem_unit.sv
// data_mem_unit: multi-cycle word-addressed data memory behind the MEM stage.
// One access at a time. mem_stall holds the pipeline for LATENCY cycles.
// Read data is registered on mem_din. Illegal requests raise a sticky mem_err.
module data_mem_unit #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        mem_stall,
  output logic        mem_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t                  state_reg, state_next;
  logic [3:0]              count_reg, count_next;
  logic                    op_write_reg, op_write_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic [31:0]             wdata_reg, wdata_next;
  logic [31:0]             din_reg;
  logic                    err_reg, err_next;

  // Storage is never reset; contents survive rst_n.
  logic [31:0] mem_array [2**ADDR_WIDTH];

  logic req;
  logic legal;
  logic accept;
  logic access_edge;

  // Request decode and legality: aligned, in range, not both read and write.
  always_comb begin
    req    = mem_valid & (mem_ren | mem_wen);
    legal  = (mem_addr[1:0] == 2'b00) &&
             ((mem_addr >> (ADDR_WIDTH + 2)) == 32'd0) &&
             !(mem_ren && mem_wen);
    accept = (state_reg == IDLE) && req && legal;
  end

  // Next-state logic; the operation is latched on acceptance so later
  // changes on mem_addr/mem_dout/mem_valid cannot disturb the access.
  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    op_write_next = op_write_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    err_next      = err_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          op_write_next = mem_wen;
          addr_next     = mem_addr[ADDR_WIDTH+1:2];
          wdata_next    = mem_dout;
          count_next    = LAT_M1;
          state_next    = (LATENCY == 1) ? DONE : WAIT;
        end else if (req) begin
          err_next = 1'b1;
        end
      end
      WAIT: begin
        count_next = count_reg - 4'd1;
        if (count_reg == 4'd1) state_next = DONE;
      end
      DONE: begin
        // Request inputs still belong to the finished instruction here.
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The edge that enters DONE performs the array access. With LATENCY==1
  // this is also the acceptance edge, hence the use of the *_next values.
  always_comb begin
    access_edge = (state_next == DONE) && (state_reg != DONE);
  end

  // Control and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      count_reg    <= 4'd0;
      op_write_reg <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= 32'd0;
      din_reg      <= 32'd0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      op_write_reg <= op_write_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      err_reg      <= err_next;
      if (access_edge && !op_write_next) din_reg <= mem_array[addr_next];
    end
  end

  // Array write port; suppressed while reset is held so an aborted
  // access can never land in memory.
  always_ff @(posedge clk) begin
    if (rst_n && access_edge && op_write_next) mem_array[addr_next] <= wdata_next;
  end

  // Outputs: stall covers the accepting IDLE cycle plus all of WAIT.
  always_comb begin
    mem_stall = accept || (state_reg == WAIT);
    busy      = (state_reg != IDLE);
    mem_din   = din_reg;
    mem_err   = err_reg;
  end

endmodule
